// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream between the host-side source and the chain loader.
interface ccff_chain_loader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words, bit 0 first, into a configuration flop chain for
// exactly CHAIN_LEN shifts and flags any 1 seen on the chain tail during the load.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_FETCH | chain paused, waiting for the next bitstream word
// ST_SHIFT | one chain shift per cycle; word boundary may refill or stall
// ST_DONE  | final shift completed, one-cycle done pulse
module ccff_chain_loader #(
    parameter int DATA_W    = 8,
    parameter int CHAIN_LEN = 32
) (
    input  logic                prog_clk,
    input  logic                pReset_n,
    input  logic                start,
    ccff_chain_loader_if.slave  s_if,
    output logic                ccff_head,
    output logic                config_enable,
    input  logic                ccff_tail,
    output logic                busy,
    output logic                done,
    output logic                tail_err
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic              ccff_head_q, ccff_head_d;
    logic              config_enable_q, config_enable_d;
    logic              tail_err_q, tail_err_d;
    logic              ready_c;
    logic [IDX_W-1:0]  bit_idx_inc;

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state_q         <= ST_IDLE;
            word_q          <= '0;
            bit_idx_q       <= '0;
            shift_cnt_q     <= '0;
            ccff_head_q     <= 1'b0;
            config_enable_q <= 1'b0;
            tail_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_q          <= word_d;
            bit_idx_q       <= bit_idx_d;
            shift_cnt_q     <= shift_cnt_d;
            ccff_head_q     <= ccff_head_d;
            config_enable_q <= config_enable_d;
            tail_err_q      <= tail_err_d;
        end
    end

    assign bit_idx_inc = (bit_idx_q == LAST_IDX) ? '0 : bit_idx_q + IDX_W'(1);

    always_comb begin
        state_d         = state_q;
        word_d          = word_q;
        bit_idx_d       = bit_idx_q;
        shift_cnt_d     = shift_cnt_q;
        ccff_head_d     = ccff_head_q;
        config_enable_d = config_enable_q;
        tail_err_d      = tail_err_q;
        ready_c         = 1'b0;

        // The chain is pre-reset to zeros, so any 1 clocked out of the tail is a fault.
        if (config_enable_q && ccff_tail) begin
            tail_err_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    shift_cnt_d = '0;
                    bit_idx_d   = '0;
                    tail_err_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                ready_c         = 1'b1;
                config_enable_d = 1'b0;
                if (s_if.s_valid) begin
                    state_d         = ST_SHIFT;
                    word_d          = s_if.s_data >> 1;
                    ccff_head_d     = s_if.s_data[0];
                    config_enable_d = 1'b1;
                    bit_idx_d       = '0;
                end
            end
            ST_SHIFT: begin
                shift_cnt_d = shift_cnt_q + CNT_W'(1);
                bit_idx_d   = bit_idx_inc;
                if (shift_cnt_q == LAST_CNT) begin
                    state_d         = ST_DONE;
                    config_enable_d = 1'b0;
                    ccff_head_d     = 1'b0;
                end else if (bit_idx_q == LAST_IDX) begin
                    // Refill on the boundary cycle so streaming stays gap-free.
                    ready_c = 1'b1;
                    if (s_if.s_valid) begin
                        word_d      = s_if.s_data >> 1;
                        ccff_head_d = s_if.s_data[0];
                    end else begin
                        state_d         = ST_FETCH;
                        config_enable_d = 1'b0;
                        ccff_head_d     = 1'b0;
                    end
                end else begin
                    word_d      = word_q >> 1;
                    ccff_head_d = word_q[0];
                end
            end
            ST_DONE: begin
                config_enable_d = 1'b0;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s_if.s_ready  = ready_c;
    assign ccff_head     = ccff_head_q;
    assign config_enable = config_enable_q;
    assign tail_err      = tail_err_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
endmodule
